// File: rtl/result_collector_if.sv
// Result collector bus bundle: core done flags, data-RAM read port and result stream.
// The collector uses the master modport; the surrounding system uses slave.
interface result_collector_if;
    logic [3:0]  DONE_IN;
    logic [15:0] RAM_ADDRESS;
    logic        RAM_READ_EN;
    logic [15:0] RAM_DATA;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic        BUSY;
    logic        COLLECT_DONE;

    modport master (
        input  DONE_IN,
        input  RAM_DATA,
        input  OUT_READY,
        output RAM_ADDRESS,
        output RAM_READ_EN,
        output OUT_DATA,
        output OUT_VALID,
        output OUT_LAST,
        output BUSY,
        output COLLECT_DONE
    );

    modport slave (
        output DONE_IN,
        output RAM_DATA,
        output OUT_READY,
        input  RAM_ADDRESS,
        input  RAM_READ_EN,
        input  OUT_DATA,
        input  OUT_VALID,
        input  OUT_LAST,
        input  BUSY,
        input  COLLECT_DONE
    );
endinterface

// File: rtl/result_collector.sv
// Result collector: waits until all four cores report done, then streams RESULT_COUNT words
// from data RAM (starting at BASE_ADDR) over a valid/ready interface, one word per
// READ -> LATCH -> HOLD pass. Returns to idle once every done flag has dropped.
// Optional feature: define RESULT_CHECKSUM_EN to append a 16-bit wrap-around sum beat
// after the last data word; that beat then carries OUT_LAST instead.
module result_collector #(
    parameter logic [15:0] BASE_ADDR    = 16'h0040,
    parameter int unsigned RESULT_COUNT = 16
) (
    input logic                MAIN_CLOCK,
    input logic                RESET_N,
    result_collector_if.master bus
);

    localparam logic [15:0] LastIdx = 16'(RESULT_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StHold,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  sticky_q, sticky_d;
    logic [15:0] out_data_q, out_data_d;
    logic        last_word;
`ifdef RESULT_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        csum_beat_q, csum_beat_d;
`endif

    assign last_word = (idx_q == LastIdx);

    // Next-state: done-flag gathering, word sequencing and output data capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
`ifdef RESULT_CHECKSUM_EN
        sum_d       = sum_q;
        csum_beat_d = csum_beat_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A flag arriving this cycle counts toward the all-done condition.
                sticky_d = sticky_q | bus.DONE_IN;
                if (&sticky_d) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StLatch;
            end
            StLatch: begin
                out_data_d = bus.RAM_DATA;
                state_d    = StHold;
            end
            StHold: begin
                if (bus.OUT_READY) begin
`ifdef RESULT_CHECKSUM_EN
                    if (csum_beat_q) begin
                        state_d = StDone;
                    end else begin
                        sum_d = sum_q + out_data_q;
                        idx_d = idx_q + 16'd1;
                        if (last_word) begin
                            // Stay in HOLD and present the running sum as an extra beat.
                            out_data_d  = sum_d;
                            csum_beat_d = 1'b1;
                        end else begin
                            state_d = StRead;
                        end
                    end
`else
                    idx_d   = idx_q + 16'd1;
                    state_d = last_word ? StDone : StRead;
`endif
                end
            end
            StDone: begin
                if (bus.DONE_IN == 4'b0000) begin
                    state_d  = StIdle;
                    sticky_d = '0;
                    idx_d    = '0;
`ifdef RESULT_CHECKSUM_EN
                    sum_d       = '0;
                    csum_beat_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge MAIN_CLOCK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            sticky_q   <= '0;
            out_data_q <= '0;
`ifdef RESULT_CHECKSUM_EN
            sum_q       <= '0;
            csum_beat_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
`ifdef RESULT_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_beat_q <= csum_beat_d;
`endif
        end
    end

    // Outputs decoded from the registered state; address forced to zero when not reading.
    always_comb begin
        bus.RAM_READ_EN  = (state_q == StRead);
        bus.RAM_ADDRESS  = bus.RAM_READ_EN ? (BASE_ADDR + idx_q) : 16'h0000;
        bus.OUT_DATA     = out_data_q;
        bus.OUT_VALID    = (state_q == StHold);
`ifdef RESULT_CHECKSUM_EN
        bus.OUT_LAST     = (state_q == StHold) && csum_beat_q;
`else
        bus.OUT_LAST     = (state_q == StHold) && last_word;
`endif
        bus.BUSY         = (state_q == StRead) || (state_q == StLatch) || (state_q == StHold);
        bus.COLLECT_DONE = (state_q == StDone);
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0040: data-RAM word address of the first result element.
REQ-002 SHALL have parameter RESULT_COUNT, default 16: number of result words to stream (legal 1..65535).
REQ-003 SHALL have port MAIN_CLOCK  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET_N  input  1: synchronous, active-low reset, sampled on MAIN_CLOCK rising edge.
REQ-005 SHALL have port DONE_IN  input  4: per-core process-finished flags, bit i = core i+1.
REQ-006 SHALL have port RAM_ADDRESS  output  16: data-RAM read address.
REQ-007 SHALL have port RAM_READ_EN  output  1: read strobe, one cycle per word.
REQ-008 SHALL have port RAM_DATA  input  16: data-RAM read data, valid the cycle after RAM_READ_EN.
REQ-009 SHALL have port OUT_DATA  output  16: streamed result word.
REQ-010 SHALL have port OUT_VALID  output  1: OUT_DATA holds a word.
REQ-011 SHALL have port OUT_READY  input  1: consumer accepts the word.
REQ-012 SHALL have port OUT_LAST  output  1: qualifies the final beat of a frame.
REQ-013 SHALL have port BUSY  output  1: high in READ, LATCH, HOLD.
REQ-014 SHALL have port COLLECT_DONE  output  1: high in DONE state.

Function
REQ-015 SHALL implement states IDLE, READ, LATCH, HOLD, DONE.
REQ-016 IDLE: SHALL set sticky bit i when DONE_IN[i]=1; SHALL go to READ the cycle after all four sticky bits are set (same cycle the fourth arrives counts).
REQ-017 READ: SHALL drive RAM_ADDRESS=BASE_ADDR+idx (16-bit wrap), RAM_READ_EN=1 for exactly one cycle, then go to LATCH.
REQ-018 LATCH: SHALL register RAM_DATA into OUT_DATA, then go to HOLD; RAM_READ_EN=0.
REQ-019 HOLD: OUT_VALID=1, OUT_DATA stable until OUT_VALID&OUT_READY; READY may be high on first HOLD cycle (transfer that cycle).
REQ-020 On transfer SHALL increment idx; if idx was RESULT_COUNT-1 go to DONE, else READ; minimum 3 cycles per word.
REQ-021 OUT_LAST SHALL be 1 only in HOLD of the final beat.
REQ-022 DONE: COLLECT_DONE=1; SHALL return to IDLE, clearing sticky bits and idx, when DONE_IN==4'b0000.
REQ-023 DONE_IN changes while BUSY SHALL be ignored; sticky bits SHALL not be cleared until DONE exit.
REQ-024 RAM_ADDRESS SHALL be 0 whenever RAM_READ_EN=0.

Reset
REQ-025 RESET_N=0 at any edge, including mid-frame, SHALL force IDLE next cycle with idx=0, sticky bits=0, OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, RAM_READ_EN=0, RAM_ADDRESS=0, BUSY=0, COLLECT_DONE=0.
REQ-026 After reset, a partially streamed frame SHALL restart from idx=0 on next all-done event.

Configuration
REQ-027 With RESULT_CHECKSUM_EN defined: SHALL keep a 16-bit wrap-around sum of streamed words (cleared on reset and DONE exit) and, after the final data word transfers, SHALL emit one extra HOLD beat with OUT_DATA=sum, OUT_LAST=1 on that beat only, then DONE.
REQ-028 Without RESULT_CHECKSUM_EN: no checksum logic or beat; OUT_LAST on final data word.

Verification
REQ-029 RESULT_COUNT=4, RAM[0x40..0x43]=1,2,3,4, DONE_IN 0001,0011,0111,1111 staggered, OUT_READY=1 -> reads 0x40..0x43, beats 1,2,3,4 every 3 cycles, OUT_LAST on 4 (checksum build: extra beat 0x000A with OUT_LAST).
REQ-030 OUT_READY held 0 for 5 cycles on beat 2 -> OUT_VALID and OUT_DATA=2 held 5 cycles, no RAM_READ_EN issued until transfer.
REQ-031 RESULT_COUNT=1, RAM[0x40]=0xFFFF, checksum build -> beats 0xFFFF then 0xFFFF/OUT_LAST; non-checksum build -> single beat with OUT_LAST.
REQ-032 RESET_N=0 for one cycle during beat 3 -> all outputs 0 next cycle; re-assert DONE_IN=1111 -> frame restarts at address 0x40.
REQ-033 DONE_IN drops to 0110 mid-frame -> frame completes unchanged; in DONE, DONE_IN=0000 -> IDLE next cycle, COLLECT_DONE=0.
REQ-034 Checksum build, words 0x8000,0x8001 -> checksum beat 0x0001 (wrap).
